tl_referee: RTL and testbench

//   Push/pop master for the transaction-layer FIFOs. Pops one 12-bit word at a time from a source FIFO.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tl_class_dec.sv | 23 ++
 rtl/tl_referee.sv | 129 ++++++++++++
 tb/tb_tl_referee.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared widths, class field position and FSM state type for the transaction-layer referee
package tl_pkg;

   localparam int DATA_W  = 12;
   localparam int CLS_W   = 2;
   localparam int CLS_MSB = DATA_W - 1;
   localparam int CLS_LSB = DATA_W - CLS_W;
   localparam int NUM_DST = 2 ** CLS_W;
   localparam int LAT_W   = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      WAIT  = 3'd2,
      ROUTE = 3'd3,
      PUSH  = 3'd4
   } tl_state_t;

endpackage

// File: rtl/tl_class_dec.sv
// rtl/tl_class_dec.sv - registered one-hot decoder turning a class index into a destination push strobe
module tl_class_dec
   import tl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [CLS_W-1:0]   cls,
   input  logic               en,
   output logic [NUM_DST-1:0] onehot
);

   // One-hot strobe is registered so it lines up with the cycle after the decision; zero whenever en is low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         onehot <= '0;
      end else if (en) begin
         onehot <= NUM_DST'(1) << cls;
      end else begin
         onehot <= '0;
      end
   end

endmodule

// File: rtl/tl_referee.sv
// rtl/tl_referee.sv - pops words from the ingress FIFO and pushes each to the per-class FIFO named by its class field
module tl_referee
   import tl_pkg::*;
#(
   parameter int RD_LATENCY = 2
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               src_empty,
   input  logic [DATA_W-1:0]  src_data,
   output logic               src_pop,
   input  logic [NUM_DST-1:0] dst_almost_full,
   output logic [NUM_DST-1:0] dst_push,
   output logic [DATA_W-1:0]  dst_data,
   output logic               busy,
   output logic [7:0]         stall_cnt,
   output logic [7:0]         word_cnt
);

   // Counter is preloaded so that it reaches zero exactly in the cycle the source data becomes valid.
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

   tl_state_t         state;
   tl_state_t         state_next;
   logic [LAT_W-1:0]  lat_cnt;
   logic [DATA_W-1:0] hold;
   logic [CLS_W-1:0]  cls;
   logic              dst_blocked;
   logic              push_start;

   assign cls         = hold[CLS_MSB:CLS_LSB];
   assign dst_blocked = dst_almost_full[cls];
   assign src_pop     = (state == POP);
   assign busy        = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; a new pop is only started from IDLE or straight out of PUSH.
   always_comb begin
      state_next = state;
      push_start = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !src_empty) begin
               state_next = POP;
            end
         end
         POP: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_next = ROUTE;
            end
         end
         ROUTE: begin
            if (!dst_blocked) begin
               state_next = PUSH;
               push_start = 1'b1;
            end
         end
         PUSH: begin
            state_next = (enable && !src_empty) ? POP : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Read-latency counter and hold register capturing the popped word when it becomes valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lat_cnt <= '0;
         hold    <= '0;
      end else begin
         if (state == POP) begin
            lat_cnt <= LAT_INIT;
         end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end
         if (state == WAIT && lat_cnt == '0) begin
            hold <= src_data;
         end
      end
   end

   // Output data bus is loaded on entry to PUSH and then held until the next push.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dst_data <= '0;
      end else if (push_start) begin
         dst_data <= hold;
      end
   end

   // Statistics: stall cycles saturate, pushed words wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
         word_cnt  <= '0;
      end else begin
         if (state == ROUTE && dst_blocked && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
         if (state == PUSH) begin
            word_cnt <= word_cnt + 8'd1;
         end
      end
   end

   tl_class_dec u_class_dec (
      .clk    (clk),
      .reset  (reset),
      .cls    (cls),
      .en     (push_start),
      .onehot (dst_push)
   );

endmodule

// File: tb/tb_tl_referee.sv
// tb/tb_tl_referee.sv - randomized and directed self-checking bench for tl_referee against a transaction-level model
module tb_tl_referee;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        src_empty;
   logic [11:0] src_data;
   logic        src_pop;
   logic [3:0]  dst_almost_full;
   logic [3:0]  dst_push;
   logic [11:0] dst_data;
   logic        busy;
   logic [7:0]  stall_cnt;
   logic [7:0]  word_cnt;

   tl_referee #(.RD_LATENCY(LAT)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .src_empty       (src_empty),
      .src_data        (src_data),
      .src_pop         (src_pop),
      .dst_almost_full (dst_almost_full),
      .dst_push        (dst_push),
      .dst_data        (dst_data),
      .busy            (busy),
      .stall_cnt       (stall_cnt),
      .word_cnt        (word_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // source FIFO contents; responder index follows the DUT, model index follows the model
   logic [11:0] words[$];
   int          r_idx = 0;
   int          m_idx = 0;
   int          src_pop_cyc = -100;
   logic [11:0] src_word = '0;

   // values applied to the DUT in the next cycle
   bit          d_reset = 1'b0;
   bit          d_en    = 1'b1;
   bit          d_starve = 1'b0;
   logic [3:0]  d_af    = '0;

   // model expectations for the current cycle
   bit          e_pop = 0, e_push = 0, e_busy = 0;
   logic [1:0]  e_cls = '0;
   logic [11:0] e_dd = '0;
   int          e_stall = 0, e_wcnt = 0;
   bit          m_inflight = 0;
   int          m_pop_c = 0;
   logic [11:0] m_word = '0;

   // observations of the DUT for directed checks
   int          pops = 0, pushes = 0, last_pop_c = -1, last_push_c = -1;
   logic [3:0]  last_push_v = '0;
   logic [11:0] last_push_d = '0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   // Advance the model one cycle using the inputs just applied.
   task automatic model_step();
      bit n_pop;
      bit n_push;
      n_pop  = 0;
      n_push = 0;
      if (e_pop) begin
         m_word = (m_idx < words.size()) ? words[m_idx] : 12'h000;
         m_idx++;
      end
      if (!d_reset) begin
         m_inflight = 0;
         e_stall    = 0;
         e_wcnt     = 0;
         e_dd       = '0;
      end else begin
         if (e_push) begin
            e_wcnt     = (e_wcnt + 1) % 256;
            m_inflight = 0;
         end
         if (e_pop) begin
            m_inflight = 1;
            m_pop_c    = cyc;
         end else if (!m_inflight) begin
            if (d_en && !src_empty) n_pop = 1;
         end else if (cyc >= m_pop_c + LAT + 1) begin
            if (!d_af[m_word[11:10]]) n_push = 1;
            else if (e_stall < 255) e_stall++;
         end
      end
      e_pop  = n_pop;
      e_push = n_push;
      if (n_push) begin
         e_dd  = m_word;
         e_cls = m_word[11:10];
      end
      e_busy = n_pop || m_inflight;
   endtask

   // One clock: compare, observe, drive, model.
   task automatic step();
      logic [3:0] exp_push;
      @(negedge clk);
      cyc++;
      exp_push = e_push ? (4'b0001 << e_cls) : 4'b0000;
      n_checks++;
      if (src_pop !== e_pop || dst_push !== exp_push || dst_data !== e_dd || busy !== e_busy ||
          stall_cnt !== 8'(e_stall) || word_cnt !== 8'(e_wcnt))
         $display("FAIL cycle_outputs @%0d: got pop=%b push=%b data=%h busy=%b stall=%0d wcnt=%0d, want pop=%b push=%b data=%h busy=%b stall=%0d wcnt=%0d",
                  cyc, src_pop, dst_push, dst_data, busy, stall_cnt, word_cnt,
                  e_pop, exp_push, e_dd, e_busy, e_stall, e_wcnt);
      else
         n_pass++;
      if (src_pop === 1'b1) begin
         pops++;
         last_pop_c  = cyc;
         src_pop_cyc = cyc;
         if (r_idx < words.size()) begin
            src_word = words[r_idx];
            r_idx++;
         end
      end
      if (dst_push !== 4'b0000) begin
         pushes++;
         last_push_c = cyc;
         last_push_v = dst_push;
         last_push_d = dst_data;
      end
      reset           = d_reset;
      enable          = d_en;
      dst_almost_full = d_af;
      src_empty       = d_starve || (r_idx >= words.size());
      src_data        = (cyc == src_pop_cyc + LAT) ? src_word : 12'($urandom);
      model_step();
   endtask

   task automatic run_until_pop(input int budget);
      int k = 0;
      int p0 = pops;
      while (pops == p0 && k < budget) begin
         step();
         k++;
      end
      check("pop_within_budget", pops - p0, 1);
   endtask

   task automatic run_until_pushes(input int target, input int budget);
      int k = 0;
      while (pushes < target && k < budget) begin
         step();
         k++;
      end
      check("pushes_within_budget", pushes, target);
   endtask

   task automatic do_reset();
      d_reset = 1'b0;
      step();
      step();
      d_reset = 1'b1;
      pops   = 0;
      pushes = 0;
   endtask

   initial begin
      int pc[4];
      logic [3:0] pv[4];
      int t;
      int prev;
      int k;

      reset = 1'b0; enable = 1'b1; src_empty = 1'b1; src_data = '0; dst_almost_full = '0;

      // reset held 3 cycles with data available, then single word A5C
      words.push_back(12'hA5C);
      d_reset = 1'b0; d_en = 1'b1;
      repeat (3) step();
      check("reset_outputs_zero", int'({src_pop, dst_push, dst_data, busy, stall_cnt, word_cnt}), 0);
      d_reset = 1'b1;
      pops = 0; pushes = 0;
      step();
      t = cyc;
      run_until_pop(10);
      check("first_pop_after_release", last_pop_c - t, 1);
      t = last_pop_c;
      run_until_pushes(1, 20);
      check("single_push_latency", last_push_c - t, 4);
      check("single_push_strobe", int'(last_push_v), 4);
      check("single_push_data", int'(last_push_d), 12'hA5C);
      step();
      check("single_word_cnt", int'(word_cnt), 1);

      // backpressure on class 0 for ten ROUTE cycles
      do_reset();
      words.push_back(12'h123);
      d_af = 4'b0001;
      run_until_pop(10);
      t = last_pop_c;
      repeat (LAT + 10) step();
      check("no_push_while_blocked", pushes, 0);
      d_af = 4'b0000;
      step();
      step();
      check("push_after_unblock", last_push_c - t, LAT + 12);
      check("stall_cnt_10", int'(stall_cnt), 10);

      // streaming four classes
      do_reset();
      words.push_back(12'h0F0); words.push_back(12'h5A5);
      words.push_back(12'h9C3); words.push_back(12'hE17);
      k = 0;
      while (pushes < 4 && k < 60) begin
         prev = pushes;
         step();
         if (pushes > prev) begin
            pc[prev] = last_push_c;
            pv[prev] = last_push_v;
         end
         k++;
      end
      check("stream_push_count", pushes, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stream_strobe_%0d", i), int'(pv[i]), 1 << i);
         if (i > 0) check($sformatf("stream_spacing_%0d", i), pc[i] - pc[i-1], 5);
      end
      step();
      check("stream_word_cnt", int'(word_cnt), 4);
      check("stream_pop_count", pops, 4);

      // enable dropped the cycle after src_pop
      do_reset();
      words.push_back(12'h4AB); words.push_back(12'hC01);
      d_en = 1'b1;
      run_until_pop(10);
      d_en = 1'b0;
      run_until_pushes(1, 20);
      check("enable_drop_strobe", int'(last_push_v), 2);
      step();
      check("enable_drop_busy_low", int'(busy), 0);
      repeat (10) step();
      check("enable_drop_single_pop", pops, 1);

      // reset during WAIT discards the word
      d_en = 1'b1;
      do_reset();
      run_until_pop(10);
      step();
      d_reset = 1'b0;
      step();
      d_reset = 1'b1;
      d_en = 1'b0;
      repeat (12) step();
      check("reset_in_wait_no_push", pushes, 0);
      check("reset_in_wait_word_cnt", int'(word_cnt), 0);
      check("reset_in_wait_stall_cnt", int'(stall_cnt), 0);
      d_en = 1'b1;

      // stall saturation
      do_reset();
      while (r_idx < words.size()) words.delete(words.size() - 1);
      words.push_back(12'h6EE);
      d_af = 4'b0010;
      run_until_pop(10);
      repeat (300) step();
      check("stall_saturates", int'(stall_cnt), 255);
      d_af = 4'b0000;
      run_until_pushes(1, 10);

      // word counter wrap
      do_reset();
      for (int i = 0; i < 257; i++) words.push_back(12'($urandom));
      run_until_pushes(257, 257 * 5 + 20);
      step();
      check("word_cnt_wraps", int'(word_cnt), 1);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         d_en     = ($urandom_range(0, 9) != 0);
         d_starve = ($urandom_range(0, 3) == 0);
         d_af     = 4'($urandom) & 4'($urandom);
         d_reset  = ($urandom_range(0, 299) != 0);
         if (words.size() - r_idx < 2) words.push_back(12'($urandom));
         step();
      end
      d_reset = 1'b1; d_starve = 1'b0; d_af = '0;
      repeat (20) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
